// File: rtl/adder_tree_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_seq_if
// Description : Handshake and data bundle between the sequential adder-tree
//               accumulator and its job source, tree and result sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_tree_seq_if #(
    parameter int SUM_W = 44,
    parameter int ACC_W = 52,
    parameter int CNT_W = 8
);
    logic                    start;
    logic [CNT_W-1:0]        len_chunks;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [SUM_W-1:0] tree_sum;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;

    // Environment side: issues jobs, feeds chunks, consumes results
    modport master (
        output start, len_chunks, in_valid, tree_sum, out_ready,
        input  in_ready, busy, out_valid, out_sum
    );

    // Accumulator side
    modport slave (
        input  start, len_chunks, in_valid, tree_sum, out_ready,
        output in_ready, busy, out_valid, out_sum
    );
endinterface
`default_nettype wire

// File: rtl/adder_tree_seq.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_seq
// Description : Sequences a multi-chunk reduction through an external
//               pipelined 16-input adder tree and accumulates the tree sums
//               into a single signed total.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_seq #(
    parameter int IL       = 4,
    parameter int FL       = 16,
    parameter int TREE_LAT = 4,
    parameter int CNT_W    = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    adder_tree_seq_if.slave    bus
);
    localparam int SUM_W = 4 + (IL + FL) * 2;
    localparam int ACC_W = SUM_W + CNT_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]              state;
    logic [CNT_W-1:0]        len_lat;
    logic [CNT_W-1:0]        chunk_cnt;
    logic [TREE_LAT-1:0]     vld_sr;
    logic signed [ACC_W-1:0] acc;

    logic                    start_take;
    logic                    beat;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    last_beat;
    logic signed [ACC_W-1:0] tree_ext;

    // Starts are only honoured in IDLE; beats only while feeding
    assign start_take = (state == ST_IDLE) && bus.start;
    assign beat       = (state == ST_FEED) && bus.in_valid;
    assign cnt_nxt    = chunk_cnt + CNT_W'(1);
    assign last_beat  = beat && (cnt_nxt == len_lat);
    assign tree_ext   = {{CNT_W{bus.tree_sum[SUM_W-1]}}, bus.tree_sum};

    assign bus.in_ready  = (state == ST_FEED);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_sum   = acc;

    // Job control: IDLE -> FEED -> DRAIN -> DONE, or IDLE -> DONE for empty jobs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (bus.start)
                              state <= (bus.len_chunks == '0) ? ST_DONE : ST_FEED;
                ST_FEED:  if (last_beat)       state <= ST_DRAIN;
                ST_DRAIN: if (vld_sr == '0)    state <= ST_DONE;
                ST_DONE:  if (bus.out_ready)   state <= ST_IDLE;
                default:                       state <= ST_IDLE;
            endcase
        end
    end

    // Job length capture and accepted-chunk counting
    always_ff @(posedge clk) begin
        if (reset) begin
            len_lat   <= '0;
            chunk_cnt <= '0;
        end else if (start_take) begin
            len_lat   <= bus.len_chunks;
            chunk_cnt <= '0;
        end else if (beat) begin
            chunk_cnt <= cnt_nxt;
        end
    end

    // Tracks which tree-output cycles carry a real chunk sum; mirrors tree latency
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | TREE_LAT'(beat);
        end
    end

    // Accumulate each tree sum as its marker leaves the tracking register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (start_take) begin
            acc <= '0;
        end else if (vld_sr[TREE_LAT-1]) begin
            acc <= acc + tree_ext;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_adder_tree_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_tree_seq
// Description : Directed self-checking bench for adder_tree_seq with a
//               behavioural TREE_LAT-deep adder-tree pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_tree_seq;
    localparam int IL    = 4;
    localparam int FL    = 16;
    localparam int TL    = 4;
    localparam int CNT_W = 8;
    localparam int SUM_W = 4 + (IL + FL) * 2;
    localparam int ACC_W = SUM_W + CNT_W;
    localparam logic signed [SUM_W-1:0] JUNK = 1000;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   ir_cnt;
    int   ir_base;
    int   lat;
    logic signed [SUM_W-1:0] feed_sum;
    logic signed [SUM_W-1:0] pipe [TL];

    adder_tree_seq_if #(.SUM_W(SUM_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    adder_tree_seq #(.IL(IL), .FL(FL), .TREE_LAT(TL), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External tree model: accepted chunk's sum appears TL cycles later, junk otherwise
    always @(posedge clk) begin
        pipe[0] <= (bus.in_valid && bus.in_ready) ? feed_sum : JUNK;
        for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.tree_sum = pipe[TL-1];

    // Counts cycles in which the block offers in_ready
    initial ir_cnt = 0;
    always @(negedge clk) if (bus.in_ready) ir_cnt <= ir_cnt + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len);
        bus.start      = 1'b1;
        bus.len_chunks = len[CNT_W-1:0];
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic feed(input longint s, input int gap);
        bus.in_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
        bus.in_valid = 1'b1;
        feed_sum     = s[SUM_W-1:0];
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_job;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    function automatic longint sum_now();
        return longint'($signed(bus.out_sum));
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.len_chunks = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        feed_sum = '0;
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", sum_now(), 0);
        reset = 1'b0;
        tick();

        // V1: single chunk
        start_job(1);
        chk("v1_in_ready", bus.in_ready, 1);
        chk("v1_busy", bus.busy, 1);
        feed(5, 0);
        wait_done(lat);
        chk("v1_latency", lat, TL + 1);
        chk("v1_sum", sum_now(), 5);
        finish_job();
        chk("v1_idle_valid", bus.out_valid, 0);
        chk("v1_idle_busy", bus.busy, 0);
        chk("v1_idle_hold", sum_now(), 5);

        // V2: three back-to-back chunks, in_valid held high throughout
        ir_base = ir_cnt;
        start_job(3);
        bus.in_valid = 1'b1;
        feed_sum = 10;
        tick();
        feed_sum = -3;
        tick();
        feed_sum = -20;
        tick();
        feed_sum = 77;
        wait_done(lat);
        bus.in_valid = 1'b0;
        chk("v2_latency", lat, TL + 1);
        chk("v2_sum", sum_now(), -13);
        chk("v2_ready_cycles", ir_cnt - ir_base, 3);
        finish_job();

        // V3: gap between beats
        start_job(2);
        feed(7, 0);
        feed(8, 3);
        wait_done(lat);
        chk("v3_latency", lat, TL + 1);
        chk("v3_sum", sum_now(), 15);
        finish_job();

        // V4: empty job, back-pressured result, start on the DONE->IDLE edge
        start_job(0);
        chk("v4_valid", bus.out_valid, 1);
        chk("v4_sum", sum_now(), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("v4_hold_valid", bus.out_valid, 1);
            chk("v4_hold_sum", sum_now(), 0);
        end
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        bus.len_chunks = '0;
        tick();
        bus.out_ready  = 1'b0;
        bus.start      = 1'b0;
        chk("v4_exit_busy", bus.busy, 0);
        chk("v4_exit_valid", bus.out_valid, 0);
        tick();
        chk("v4_no_start_busy", bus.busy, 0);

        // V5: reset during DRAIN with two sums still in flight
        start_job(3);
        feed(1, 0);
        feed(2, 0);
        feed(4, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("v5_busy", bus.busy, 0);
        chk("v5_valid", bus.out_valid, 0);
        chk("v5_sum", sum_now(), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("v5_ignored_sums", sum_now(), 0);
        chk("v5_still_idle", bus.busy, 0);

        // V6: start during FEED must not disturb the running job
        start_job(2);
        feed(6, 0);
        bus.start      = 1'b1;
        bus.len_chunks = 8'd5;
        tick();
        bus.start      = 1'b0;
        feed(9, 0);
        wait_done(lat);
        chk("v6_latency", lat, TL + 1);
        chk("v6_sum", sum_now(), 15);
        finish_job();
        chk("v6_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
